// File: rtl/counter_pkg.sv
// ============================================================================
// Module      : counter_pkg
// Description : Shared direction/mode constants and the load clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // Operands are zero-extended to 32 bits by the caller, so one function
    // serves every WIDTH up to 32.
    function automatic logic [31:0] clamp(input logic [31:0] value,
                                          input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_next_logic.sv
// ============================================================================
// Module      : counter_next_logic
// Description : Combinational next-count and boundary-event generation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_next_logic
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 15,
    parameter int          SATURATE = 0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    output logic [WIDTH-1:0] next_count,
    output logic             boundary_event
);

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero = '0;

    logic [WIDTH-1:0] w_next;
    logic             w_boundary;

    // Wrap targets are explicit so a modulus below 2**WIDTH behaves correctly.
    always_comb begin
        w_next     = count;
        w_boundary = 1'b0;
        if (clear) begin
            w_next = c_zero;
        end else if (load) begin
            w_next = WIDTH'(clamp(32'(load_value), 32'(c_max)));
        end else if (enable) begin
            if (up_down == DIR_UP) begin
                if (count >= c_max) begin
                    w_boundary = 1'b1;
                    w_next     = (SATURATE == MODE_SAT) ? c_max : c_zero;
                end else begin
                    w_next = count + c_one;
                end
            end else begin
                if (count == c_zero) begin
                    w_boundary = 1'b1;
                    w_next     = (SATURATE == MODE_SAT) ? c_zero : c_max;
                end else begin
                    w_next = count - c_one;
                end
            end
        end
    end

    assign next_count     = w_next;
    assign boundary_event = w_boundary;

endmodule

`default_nettype wire

// File: rtl/param_updown_counter.sv
// ============================================================================
// Module      : param_updown_counter
// Description : Parametrised up/down counter with load, clear, wrap/saturate,
//               terminal-count pulse and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int          SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next_count;
    logic             w_boundary;

    counter_next_logic #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .count          (r_count),
        .enable         (enable),
        .up_down        (up_down),
        .load           (load),
        .load_value     (load_value),
        .clear          (clear),
        .next_count     (w_next_count),
        .boundary_event (w_boundary)
    );

    // A boundary event on the same edge as ovf_clr leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_tc    <= w_boundary;
            if (clear)
                r_ovf <= 1'b0;
            else if (w_boundary)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule

`default_nettype wire
